// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - Wishbone-programmed serial loader for an FPGA configuration chain
module fpga_cfg_loader (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ccff_head,
    input  logic        ccff_tail,
    output logic        prog_clk,
    output logic        prog_reset,
    output logic        irq
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  div;
    logic        ie;
    logic [31:0] bitcnt, tailsig, sreg, rdata;
    logic        done, overflow, tail_bit;
    logic [7:0]  phase_cnt;
    logic [4:0]  bit_idx;

    logic [31:0] fifo_mem [8];
    logic [2:0]  wr_ptr, rd_ptr;
    logic [3:0]  level;

    logic        req, wr, rd;
    logic [2:0]  reg_sel;
    logic        ctrl_wr, status_wr, data_wr, bitcnt_wr;
    logic        start, abort, busy, stall, pop, push, fifo_full, fifo_empty;
    logic        phase_end, bit_done;
    logic        unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // A request is taken only when no ack is outstanding, so acks never abut.
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign reg_sel   = wbs_adr_i[4:2];
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign ctrl_wr   = wr & (reg_sel == 3'd0);
    assign status_wr = wr & (reg_sel == 3'd1);
    assign data_wr   = wr & (reg_sel == 3'd2);
    assign bitcnt_wr = wr & (reg_sel == 3'd3);

    assign start = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0];
    assign abort = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[1];

    assign fifo_full  = (level == 4'd8);
    assign fifo_empty = (level == 4'd0);
    assign busy       = (state != S_IDLE);
    assign stall      = (state == S_LOAD) & fifo_empty;
    assign pop        = (state == S_LOAD) & ~fifo_empty & ~abort;
    assign push       = data_wr & (wbs_sel_i == 4'hF) & (~fifo_full | pop);
    assign phase_end  = (phase_cnt == div);
    assign bit_done   = (state == S_SHIFT_HI) & phase_end & ~abort;
    assign irq        = done & ie;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start) state_nx = (bitcnt != 32'd0) ? S_LOAD : S_DONE;
            S_LOAD:     if (!fifo_empty) state_nx = S_SHIFT_LO;
            S_SHIFT_LO: if (phase_end) state_nx = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (phase_end) begin
                    if (bitcnt == 32'd1)
                        state_nx = S_DONE;
                    else if (bit_idx == 5'd31)
                        state_nx = S_LOAD;
                    else
                        state_nx = S_SHIFT_LO;
                end
            end
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // prog_clk is registered from the next state, so it is high exactly in SHIFT_HI.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
            sreg      <= '0;
            phase_cnt <= '0;
            bit_idx   <= '0;
            tail_bit  <= 1'b0;
            tailsig   <= '0;
        end else begin
            state    <= state_nx;
            prog_clk <= (state_nx == S_SHIFT_HI);
            if (state_nx != state)
                phase_cnt <= '0;
            else if (state == S_SHIFT_LO || state == S_SHIFT_HI)
                phase_cnt <= phase_cnt + 8'd1;
            if (pop) begin
                sreg      <= fifo_mem[rd_ptr];
                ccff_head <= fifo_mem[rd_ptr][31];
                bit_idx   <= '0;
            end
            // Sample the tail before this bit's rising prog_clk edge reaches the chain.
            if (state == S_SHIFT_LO && phase_end)
                tail_bit <= ccff_tail;
            if (bit_done) begin
                tailsig <= {tailsig[30:0], tail_bit};
                if (state_nx == S_SHIFT_LO) begin
                    sreg      <= {sreg[30:0], 1'b0};
                    ccff_head <= sreg[30];
                    bit_idx   <= bit_idx + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div        <= 8'd3;
            ie         <= 1'b0;
            prog_reset <= 1'b1;
            bitcnt     <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (ctrl_wr && wbs_sel_i[0]) begin
                prog_reset <= wbs_dat_i[2];
                ie         <= wbs_dat_i[3];
            end
            if (ctrl_wr && wbs_sel_i[1] && !busy)
                div <= wbs_dat_i[15:8];
            if (bitcnt_wr && !busy) begin
                for (int i = 0; i < 4; i++)
                    if (wbs_sel_i[i]) bitcnt[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end else if (bit_done) begin
                bitcnt <= bitcnt - 32'd1;
            end
            if (abort)
                done <= 1'b0;
            else if (state == S_DONE)
                done <= 1'b1;
            else if (status_wr && wbs_sel_i[0] && wbs_dat_i[3])
                done <= 1'b0;
            if (data_wr && wbs_sel_i == 4'hF && fifo_full && !pop)
                overflow <= 1'b1;
            else if (status_wr && wbs_sel_i[0] && wbs_dat_i[4])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop)  rd_ptr <= rd_ptr + 3'd1;
            level <= level + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr] <= wbs_dat_i;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0: rdata = {16'd0, div, 4'd0, ie, prog_reset, 2'd0};
            3'd1: rdata = {20'd0, level, 2'd0, stall, overflow, done, fifo_empty, fifo_full, busy};
            3'd3: rdata = bitcnt;
            3'd4: rdata = tailsig;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - randomized self-checking bench for fpga_cfg_loader
module tb_fpga_cfg_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack, head, tail, pclk, preset, irq;
    logic [31:0] dat_o;

    localparam logic [31:0] A_CTRL = 32'h0, A_STATUS = 32'h4, A_DATA = 32'h8;
    localparam logic [31:0] A_BITCNT = 32'hC, A_TAIL = 32'h10;

    always #5 clk = ~clk;

    fpga_cfg_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .ccff_head(head), .ccff_tail(tail), .prog_clk(pclk), .prog_reset(preset), .irq(irq)
    );

    // Four-stage chain clocked by prog_clk, optionally closing the loop back to ccff_tail.
    logic       loop_en = 1'b0, chain_clr = 1'b1;
    logic [3:0] chain;
    always @(posedge pclk or posedge chain_clr)
        if (chain_clr) chain <= '0;
        else           chain <= {chain[2:0], head};
    assign tail = loop_en ? chain[3] : 1'b0;

    int n_vec = 0, n_err = 0;
    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference model: expected bit stream (MSB-first of accepted words) and settings.
    bit   exp_bits[$];
    int   div_m = 3;
    bit   ie_m = 1'b0, ovf_m = 1'b0;
    int   pulse_idx = 0, last_rise = 0, cyc_n = 0, hi_w = 0;
    bit   skip_width = 1'b0, prev_ack = 1'b0, prev_pclk = 1'b0;
    logic rise_bit = 1'b0;
    logic [7:0] first_bits = '0;

    function automatic logic [31:0] status_m(int lvl, bit busy, bit dn, bit ovf, bit stl);
        return {20'd0, 4'(lvl), 2'd0, stl, ovf, dn, lvl == 0, lvl == 8, busy};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rst) begin
                prev_ack  = 1'b0;
                prev_pclk = 1'b0;
            end else begin
                check("ack_single", 32'(ack & prev_ack), 32'd0);
                if (!ack) check("dat_idle", dat_o, 32'd0);
                if (pclk && !prev_pclk) begin
                    if (exp_bits.size() == 0) check("extra_pulse", 32'd1, 32'd0);
                    else check("head_bit", 32'(head), 32'(exp_bits.pop_front()));
                    if (pulse_idx % 32 != 0) check("bit_period", cyc_n - last_rise, 2 * (div_m + 1));
                    if (pulse_idx < 8) first_bits[7 - pulse_idx] = head;
                    last_rise = cyc_n;
                    pulse_idx++;
                    hi_w      = 0;
                    rise_bit  = head;
                end else if (pclk) begin
                    check("head_stable", 32'(head), 32'(rise_bit));
                end
                if (pclk) hi_w++;
                if (!pclk && prev_pclk && !skip_width) check("hi_width", hi_w, div_m + 1);
                prev_ack  = ack;
                prev_pclk = pclk;
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (ack) break;
        end
        if (!ack) check("wb_timeout", 32'd0, 32'd1);
        q   = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, s, q);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, 4'hF, q);
    endtask

    task automatic push_word(input logic [31:0] w);
        wb_write(A_DATA, w, 4'hF);
        if (exp_bits.size() / 32 < 8) begin
            for (int j = 31; j >= 0; j--) exp_bits.push_back(w[j]);
        end else begin
            ovf_m = 1'b1;
        end
    endtask

    task automatic set_ctrl(input int dv);
        div_m = dv;
        wb_write(A_CTRL, 32'(dv << 8) | 32'(ie_m) << 3, 4'h3);
    endtask

    task automatic start_run(input logic [31:0] bc);
        pulse_idx  = 0;
        skip_width = 1'b0;
        wb_write(A_BITCNT, bc, 4'hF);
        wb_write(A_CTRL, (32'(ie_m) << 3) | 32'd1, 4'h1);
    endtask

    task automatic wait_done(input int limit);
        logic [31:0] st;
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            wb_read(A_STATUS, st);
            if (st[3]) begin ok = 1'b1; break; end
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    // The partially consumed last word is discarded by the loader.
    task automatic finish_run();
        int rem;
        rem = exp_bits.size() % 32;
        repeat (rem) void'(exp_bits.pop_front());
    endtask

    initial begin
        logic [31:0] r, st, w1, w2, exp_tail;
        int p0, nw, bc, lvl;
        bit stream[$];
        bit ok;

        repeat (2) @(posedge clk); #1;
        check("rst_prog_clk", 32'(pclk), 32'd0);
        check("rst_head", 32'(head), 32'd0);
        check("rst_prog_reset", 32'(preset), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst = 1'b0; chain_clr = 1'b0;
        @(posedge clk); #1;
        wb_read(A_CTRL, r);   check("rst_ctrl", r, 32'h0000_0304);
        wb_read(A_STATUS, r); check("rst_status", r, 32'h0000_0004);
        wb_read(A_BITCNT, r); check("rst_bitcnt", r, 32'd0);
        wb_read(A_TAIL, r);   check("rst_tailsig", r, 32'd0);
        wb_read(A_DATA, r);   check("data_reads_zero", r, 32'd0);
        wb_read(32'h1C, r);   check("unmapped_zero", r, 32'd0);
        wb_write(A_BITCNT, 32'hFFFF_FFFF, 4'h2);
        wb_read(A_BITCNT, r); check("bitcnt_byte_lane", r, 32'h0000_FF00);

        // Single word at div=0 with interrupt enabled.
        ie_m = 1'b1;
        set_ctrl(0);
        check("prog_reset_released", 32'(preset), 32'd0);
        push_word(32'hA5A5_0F0F);
        start_run(32);
        wait_done(200);
        check("pulses_single", pulse_idx, 32);
        check("stream_single", exp_bits.size(), 0);
        check("first_bits", 32'(first_bits), 32'h0000_00A5);
        check("irq_done", 32'(irq), 32'd1);
        wb_read(A_BITCNT, r); check("bitcnt_zero", r, 32'd0);
        wb_write(A_STATUS, 32'h18, 4'h1);
        check("irq_cleared", 32'(irq), 32'd0);

        // Zero-length run finishes immediately.
        start_run(0);
        @(posedge clk); #1;
        check("zero_len_done", 32'(irq), 32'd1);
        check("zero_len_pulses", pulse_idx, 0);
        wb_write(A_STATUS, 32'h18, 4'h1);

        // Partial-lane DATA write is ignored; ninth word overflows.
        wb_write(A_DATA, 32'h1234_5678, 4'h7);
        wb_read(A_STATUS, r); check("data_partial_sel", r, 32'h0000_0004);
        for (int i = 0; i < 9; i++) push_word($urandom);
        wb_read(A_STATUS, r);
        check("status_overflow", r, status_m(exp_bits.size() / 32, 1'b0, 1'b0, ovf_m, 1'b0));
        check("status_overflow_lit", r, 32'h0000_0812);
        set_ctrl($urandom_range(0, 1));
        start_run(256);
        wait_done(2000);
        check("pulses_eight_words", pulse_idx, 256);
        check("stream_eight_words", exp_bits.size(), 0);
        wb_read(A_STATUS, r); check("status_after_ovf_run", r, status_m(0, 1'b0, 1'b1, ovf_m, 1'b0));
        wb_write(A_STATUS, 32'h18, 4'h1); ovf_m = 1'b0;
        wb_read(A_STATUS, r); check("status_w1c", r, 32'h0000_0004);

        // Stall on empty FIFO, then resume.
        push_word($urandom);
        start_run(64);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            wb_read(A_STATUS, st);
            if (st[5]) begin ok = 1'b1; break; end
        end
        check("stall_seen", 32'(ok), 32'd1);
        check("stall_busy", 32'(st[0]), 32'd1);
        check("stall_pclk_low", 32'(pclk), 32'd0);
        check("stall_pulses", pulse_idx, 32);
        wb_write(A_BITCNT, 32'd5, 4'hF);
        wb_read(A_BITCNT, r); check("bitcnt_busy_ignored", r, 32'd32);
        push_word($urandom);
        wait_done(2000);
        check("pulses_resumed", pulse_idx, 64);
        check("stream_resumed", exp_bits.size(), 0);
        wb_write(A_STATUS, 32'h18, 4'h1);

        // Loopback through the four-stage chain.
        loop_en = 1'b1; chain_clr = 1'b1; #1; chain_clr = 1'b0;
        w1 = $urandom; w2 = $urandom;
        push_word(w1); push_word(w2);
        for (int j = 31; j >= 0; j--) stream.push_back(w1[j]);
        for (int j = 31; j >= 0; j--) stream.push_back(w2[j]);
        start_run(36);
        wait_done(2000);
        check("pulses_loop", pulse_idx, 36);
        exp_tail = '0;
        for (int k = 0; k < 36; k++) exp_tail = {exp_tail[30:0], (k < 4) ? 1'b0 : stream[k - 4]};
        wb_read(A_TAIL, r);
        check("tailsig_loop", r, exp_tail);
        check("tailsig_first_word", r, w1);
        finish_run();
        wb_read(A_STATUS, r); check("status_loop", r, status_m(exp_bits.size() / 32, 1'b0, 1'b1, 1'b0, 1'b0));
        loop_en = 1'b0;
        wb_write(A_STATUS, 32'h18, 4'h1);

        // Abort in SHIFT_HI.
        set_ctrl(3);
        push_word($urandom); push_word($urandom);
        start_run(64);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (pclk) break;
        end
        check("abort_hi_seen", 32'(pclk), 32'd1);
        skip_width = 1'b1;
        wb_write(A_CTRL, (32'(ie_m) << 3) | 32'd2, 4'h1);
        check("abort_pclk_low", 32'(pclk), 32'd0);
        wb_read(A_STATUS, r); check("abort_status", r, status_m(0, 1'b0, 1'b0, 1'b0, 1'b0));
        wb_read(A_BITCNT, r); check("abort_bitcnt", r, 32'(64 - (pulse_idx - 1)));
        exp_bits.delete();

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            set_ctrl($urandom_range(0, 2));
            nw = $urandom_range(1, 3);
            repeat (nw) push_word($urandom);
            bc = $urandom_range(1, 32 * nw);
            start_run(bc);
            wait_done(2000);
            check("rand_pulses", pulse_idx, bc);
            finish_run();
            lvl = exp_bits.size() / 32;
            wb_read(A_STATUS, r); check("rand_status", r, status_m(lvl, 1'b0, 1'b1, 1'b0, 1'b0));
            wb_write(A_STATUS, 32'h18, 4'h1);
            wb_write(A_CTRL, (32'(ie_m) << 3) | 32'd2, 4'h1);
            exp_bits.delete();
            wb_read(A_STATUS, r); check("rand_flushed", r, 32'h0000_0004);
        end

        // Asynchronous reset in the middle of a high phase.
        set_ctrl(3);
        push_word($urandom);
        start_run(32);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (pclk) break;
        end
        check("rst_hi_seen", 32'(pclk), 32'd1);
        skip_width = 1'b1;
        #3 rst = 1'b1;
        #1 check("rst_async_pclk", 32'(pclk), 32'd0);
        exp_bits.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        p0 = pulse_idx;
        repeat (20) @(posedge clk);
        #1;
        check("no_pulse_after_rst", pulse_idx, p0);
        check("pclk_low_after_rst", 32'(pclk), 32'd0);
        check("prog_reset_after_rst", 32'(preset), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have one clock and one reset: wb_clk_i  in  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL have wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have the Wishbone responder ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each; wbs_sel_i  in  4; wbs_dat_i, wbs_adr_i  in  32; wbs_ack_o  out  1; wbs_dat_o  out  32.
REQ-004 SHALL have ccff_head  out  1  serial configuration data into the fabric chain.
REQ-005 SHALL have ccff_tail  in  1  chain output, captured for readback.
REQ-006 SHALL have prog_clk  out  1  generated chain clock, registered.
REQ-007 SHALL have prog_reset  out  1  chain reset, driven from CTRL.
REQ-008 SHALL have irq  out  1  level interrupt, high while DONE is set and CTRL.ie=1.

Function
REQ-009 SHALL decode wbs_adr_i[4:2]: 0=CTRL, 1=STATUS, 2=DATA (write-only), 3=BITCNT, 4=TAILSIG (read-only); all other offsets read 0 and ignore writes.
REQ-010 SHALL give CTRL these fields: bit0 start (self-clearing), bit1 abort (self-clearing), bit2 prog_reset (reset 1), bit3 ie, bits[15:8] div (reset 8'd3).
REQ-011 SHALL give STATUS these fields: bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 done (sticky, write-1-clear), bit4 overflow (sticky, W1C), bit5 stall, bits[11:8] fifo level 0..8.
REQ-012 SHALL assert wbs_ack_o for exactly one cycle, one cycle after wbs_stb_i&wbs_cyc_i is sampled high, and never in two consecutive cycles; wbs_dat_o SHALL be valid in the ack cycle and 0 otherwise.
REQ-013 SHALL apply byte writes per wbs_sel_i to CTRL and BITCNT; a DATA push SHALL require wbs_sel_i==4'hF and SHALL otherwise be acked and ignored.
REQ-014 SHALL implement an 8-deep x 32-bit FIFO; a DATA write while full SHALL still be acked, SHALL drop the word and SHALL set overflow.
REQ-015 SHALL implement the FSM IDLE -> LOAD -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LOAD | DONE) -> IDLE.
REQ-016 SHALL move from IDLE on start=1 to LOAD if BITCNT>0, and straight to DONE if BITCNT==0.
REQ-017 SHALL, in LOAD, pop one FIFO word into a 32-bit shift register; if the FIFO is empty it SHALL remain in LOAD with stall=1 and prog_clk=0.
REQ-018 SHALL shift MSB-first: ccff_head takes the shift-register MSB on entry to SHIFT_LO and SHALL be stable for the whole SHIFT_LO+SHIFT_HI bit period.
REQ-019 SHALL hold prog_clk=0 in SHIFT_LO and prog_clk=1 in SHIFT_HI, each phase lasting div+1 cycles; the bit period SHALL be 2*(div+1) cycles.
REQ-020 SHALL, on the SHIFT_HI -> next transition, decrement BITCNT, shift ccff_tail into the LSB of TAILSIG, and go to DONE if BITCNT reaches 0, to LOAD if 32 bits of the word are consumed, and to SHIFT_LO otherwise.
REQ-021 SHALL, in DONE, set STATUS.done, drive prog_clk=0, and return to IDLE in the next cycle.
REQ-022 SHALL ignore start while busy (busy = state is not IDLE).
REQ-023 SHALL, on abort, return to IDLE within one cycle from any state, force prog_clk=0, flush the FIFO, and leave done clear and BITCNT unchanged.
REQ-024 SHALL accept a DATA push and an internal pop in the same cycle, leaving the level unchanged; a push while full with a simultaneous pop SHALL succeed.
REQ-025 SHALL ignore CTRL.div and BITCNT writes while busy.

Reset
REQ-026 SHALL, on wb_rst_i: state=IDLE, FIFO empty, prog_clk=0, ccff_head=0, prog_reset=1, irq=0, wbs_ack_o=0, wbs_dat_o=0, BITCNT=0, TAILSIG=0, all sticky bits=0, div=3.
REQ-027 SHALL, on reset asserted mid-shift, force prog_clk low asynchronously with no partial high pulse after deassertion.

Verification
REQ-028 SHALL be tested: div=0, BITCNT=32, DATA=0xA5A5_0F0F, start -> 32 prog_clk pulses of period 2 cycles; ccff_head bit sequence 1010_0101...; done=1; irq=1 if ie=1.
REQ-029 SHALL be tested: ccff_tail looped to ccff_head through a 4-bit shift on prog_clk, BITCNT=36, two words -> TAILSIG ends with the first 32 bits of stream delayed by 4.
REQ-030 SHALL be tested: 9 DATA writes with no start -> level=8, full=1, overflow=1, 9th word absent from the shifted stream.
REQ-031 SHALL be tested: BITCNT=64, one word pushed, start -> stall=1 after bit 32 with prog_clk=0; second push -> shifting resumes, 64 total pulses.
REQ-032 SHALL be tested: abort during SHIFT_HI with div=3 -> prog_clk=0 on the next cycle, busy=0, level=0.
REQ-033 SHALL be tested: start with BITCNT=0 -> done set within 2 cycles, 0 prog_clk pulses.
